// File: rtl/mem_stream_writer_if.sv
// mem_stream_writer_if: stream input and memory write-port bundle for mem_stream_writer
interface mem_stream_writer_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 8
);
    logic                  START_I;
    logic [ADDR_WIDTH-1:0] BASE_I;
    logic [ADDR_WIDTH-1:0] LEN_I;
    logic                  ABORT_I;
    logic [DATA_WIDTH-1:0] DATA_I;
    logic                  VALID_I;
    logic                  READY_O;
    logic [ADDR_WIDTH-1:0] WADDR_O;
    logic [DATA_WIDTH-1:0] WDATA_O;
    logic                  WENB_O;
    logic                  BUSY_O;
    logic                  DONE_O;
    logic [ADDR_WIDTH:0]   COUNT_O;

    modport slave (
        input  START_I, BASE_I, LEN_I, ABORT_I, DATA_I, VALID_I,
        output READY_O, WADDR_O, WDATA_O, WENB_O, BUSY_O, DONE_O, COUNT_O
    );

    modport master (
        output START_I, BASE_I, LEN_I, ABORT_I, DATA_I, VALID_I,
        input  READY_O, WADDR_O, WDATA_O, WENB_O, BUSY_O, DONE_O, COUNT_O
    );
endinterface

// File: rtl/mem_stream_writer.sv
// mem_stream_writer: commits a valid/ready word stream to consecutive memory addresses from a base
module mem_stream_writer #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 8
) (
    input logic             CLK_I,
    input logic             RST_I,
    mem_stream_writer_if.slave bus
);
    typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [ADDR_WIDTH-1:0] len_q;
    logic [ADDR_WIDTH-1:0] waddr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [ADDR_WIDTH:0]   count_q;
    logic                  wenb_q;
    logic                  done_q;
    logic                  ready;
    logic                  busy;
    logic                  hs;
    logic                  last;

    assign hs   = bus.VALID_I && ready;
    assign last = count_q == {1'b0, len_q};

    // state register
    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // next state: abort beats the final handshake, DONE always falls back to IDLE
    always_comb begin
        state_d = (state_q == IDLE) ? (bus.START_I ? LOAD : IDLE) :
                  (state_q == LOAD) ? (bus.ABORT_I ? IDLE : (hs && last) ? DONE : LOAD) :
                  IDLE;
    end

    // state-decoded outputs; ready never looks at VALID_I
    always_comb begin
        ready = (state_q == LOAD) && !bus.ABORT_I;
        busy  = (state_q == LOAD) || (state_q == DONE);
    end

    // burst datapath: address/count/length latched on start, write port loaded per handshake
    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            addr_q  <= '0;
            len_q   <= '0;
            count_q <= '0;
            waddr_q <= '0;
            wdata_q <= '0;
            wenb_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            wenb_q <= hs;
            done_q <= state_q == DONE;
            if (state_q == IDLE && bus.START_I) begin
                addr_q  <= bus.BASE_I;
                len_q   <= bus.LEN_I;
                count_q <= '0;
            end
            if (hs) begin
                waddr_q <= addr_q;
                wdata_q <= bus.DATA_I;
                addr_q  <= addr_q + 1'b1;
                count_q <= count_q + 1'b1;
            end
        end
    end

    assign bus.READY_O = ready;
    assign bus.BUSY_O  = busy;
    assign bus.WADDR_O = waddr_q;
    assign bus.WDATA_O = wdata_q;
    assign bus.WENB_O  = wenb_q;
    assign bus.DONE_O  = done_q;
    assign bus.COUNT_O = count_q;
endmodule

// File: tb/tb_mem_stream_writer.sv
// tb_mem_stream_writer: randomized bench against a burst-level reference model
module tb_mem_stream_writer;
    localparam int DW    = 16;
    localparam int AW    = 8;
    localparam int DEPTH = 1 << AW;

    logic CLK_I = 1'b0;
    logic RST_I = 1'b0;

    always #5 CLK_I = ~CLK_I;

    mem_stream_writer_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    mem_stream_writer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .CLK_I(CLK_I),
        .RST_I(RST_I),
        .bus  (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // model: 0 idle, 1 loading, 2 finishing
    int m_st, m_addr, m_len, m_cnt, e_a, e_d, n_wr;
    bit e_w, e_done;
    logic [DW-1:0] ref_mem [DEPTH];
    logic [DW-1:0] dut_mem [DEPTH];

    // memory macro stand-in: commits whatever the write port presents
    always @(posedge CLK_I) if (bus.WENB_O) dut_mem[bus.WADDR_O] <= bus.WDATA_O;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_st = 0; m_cnt = 0; m_addr = 0; m_len = 0;
        e_w = 0; e_a = 0; e_d = 0; e_done = 0;
    endtask

    task automatic idle_inputs();
        bus.START_I = 0; bus.BASE_I = '0; bus.LEN_I = '0;
        bus.ABORT_I = 0; bus.DATA_I = '0; bus.VALID_I = 0;
    endtask

    // one clock: check combinational outputs, advance model, then check registered outputs
    task automatic tick();
        bit hs, ab;
        #1;
        ab = bus.ABORT_I;
        chk("ready", bus.READY_O, 32'(m_st == 1 && !ab));
        chk("busy", bus.BUSY_O, 32'(m_st != 0));
        hs = m_st == 1 && !ab && bus.VALID_I;
        e_done = m_st == 2;
        e_w = hs;
        if (hs) begin
            e_a = m_addr;
            e_d = bus.DATA_I;
            ref_mem[m_addr] = bus.DATA_I;
            m_addr = (m_addr + 1) % DEPTH;
            m_cnt++;
        end
        case (m_st)
            0: if (bus.START_I) begin
                m_st = 1; m_addr = bus.BASE_I; m_len = bus.LEN_I; m_cnt = 0;
            end
            1: if (ab) m_st = 0; else if (hs && m_cnt == m_len + 1) m_st = 2;
            default: m_st = 0;
        endcase
        @(posedge CLK_I);
        @(negedge CLK_I);
        chk("wenb", bus.WENB_O, 32'(e_w));
        chk("done", bus.DONE_O, 32'(e_done));
        chk("waddr", bus.WADDR_O, e_a);
        chk("wdata", bus.WDATA_O, e_d);
        chk("count", bus.COUNT_O, m_cnt);
        if (bus.WENB_O) n_wr++;
    endtask

    // vmode: 0 held, 1 random, 2 fixed toggle pattern; dmode: 0 descending, 1 A0-based, 2 random
    task automatic burst(input int base, input int len, input int vmode, input int dmode,
                         input int abort_at, input int restart_at);
        int cyc = 0;
        bit pat [7] = '{1, 0, 0, 1, 1, 0, 1};
        bus.START_I = 1; bus.BASE_I = AW'(base); bus.LEN_I = AW'(len);
        bus.VALID_I = 0; bus.ABORT_I = 0;
        tick();
        bus.START_I = 0;
        while (m_st == 1 && cyc < 2000) begin
            bus.VALID_I = vmode == 0 ? 1'b1 : vmode == 1 ? 1'($urandom_range(0, 1)) :
                          cyc < 7 ? pat[cyc] : 1'b1;
            bus.DATA_I  = dmode == 0 ? DW'(16'h00FF - m_cnt) : dmode == 1 ? DW'(16'h00A0 + m_cnt) :
                          DW'($urandom);
            bus.ABORT_I = abort_at >= 0 && m_cnt == abort_at && bus.VALID_I;
            bus.START_I = cyc == restart_at;
            bus.BASE_I  = 8'h80;
            tick();
            cyc++;
        end
        if (m_st == 1) chk("burst_bound", cyc, 0);
        idle_inputs();
        tick();
    endtask

    initial begin
        idle_inputs();
        model_reset();
        #1 RST_I = 1;
        #1;
        chk("rst_wenb", bus.WENB_O, 0);
        chk("rst_busy", bus.BUSY_O, 0);
        chk("rst_ready", bus.READY_O, 0);
        chk("rst_done", bus.DONE_O, 0);
        chk("rst_count", bus.COUNT_O, 0);
        @(negedge CLK_I);
        RST_I = 0;
        tick();

        n_wr = 0;
        burst(8'h00, 8'hFF, 0, 0, -1, -1);
        chk("fill_writes", n_wr, 256);
        chk("fill_count", bus.COUNT_O, 256);
        tick();
        for (int a = 0; a < DEPTH; a++) chk("fill_mem", dut_mem[a], 32'h00FF - a);
        for (int a = 0; a < DEPTH; a++) chk("fill_ref", dut_mem[a], ref_mem[a]);

        burst(8'hFE, 3, 0, 1, -1, -1);
        chk("wrap_fe", dut_mem[8'hFE], 16'h00A0);
        chk("wrap_ff", dut_mem[8'hFF], 16'h00A1);
        chk("wrap_00", dut_mem[8'h00], 16'h00A2);
        chk("wrap_01", dut_mem[8'h01], 16'h00A3);

        n_wr = 0;
        burst(8'h30, 4, 2, 2, -1, -1);
        chk("bp_pulses", n_wr, 5);

        n_wr = 0;
        burst(8'h40, 9, 0, 2, 2, -1);
        chk("abort_writes", n_wr, 2);
        chk("abort_count", bus.COUNT_O, 2);
        chk("abort_busy", bus.BUSY_O, 0);

        burst(8'h10, 7, 0, 2, -1, 2);
        chk("restart_last", dut_mem[8'h17], ref_mem[8'h17]);

        bus.START_I = 1; bus.BASE_I = 8'h20; bus.LEN_I = 9;
        tick();
        bus.START_I = 0; bus.VALID_I = 1;
        repeat (4) begin bus.DATA_I = DW'($urandom); tick(); end
        #2 RST_I = 1;
        #1;
        chk("arst_wenb", bus.WENB_O, 0);
        chk("arst_busy", bus.BUSY_O, 0);
        chk("arst_ready", bus.READY_O, 0);
        chk("arst_count", bus.COUNT_O, 0);
        idle_inputs();
        @(negedge CLK_I);
        RST_I = 0;
        model_reset();
        tick();
        burst(8'h55, 2, 0, 2, -1, -1);
        chk("arst_new_base", dut_mem[8'h57], ref_mem[8'h57]);

        repeat (20) begin
            burst(int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(0, 40)), 1, 2,
                  $urandom_range(0, 3) == 0 ? int'($urandom_range(0, 10)) : -1,
                  int'($urandom_range(0, 20)));
        end
        tick();
        for (int a = 0; a < DEPTH; a++) chk("rand_mem", dut_mem[a], ref_mem[a]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
